// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Two-stage issue/retire wrapper around an external combinational ALU.
//   S1 decodes ALUOp/funct into the 4-bit ALU control code and registers the
//   operands and the code. These registers drive the ALU directly. S2 captures
//   the ALU result and the illegal bit, and keeps the architectural NZCV
//   register, which is updated only by legal flag-setting ops. A condition
//   code is evaluated combinationally against the flags.
//
// Configuration macro:
//   ALU_FLAG_BYPASS_EN - when defined, the condition is evaluated on the live
//   ALU flags (NZCV_i) in the cycle a legal flag-setting op moves S1->S2, so a
//   branch resolves in the same cycle as the op that sets its flags. When
//   undefined, the condition always uses the registered flags.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   upstream handshake into S1
//   alu_op_i, funct_i         main-control ALUOp and R-type funct field
//   srcA_i, srcB_i, flag_we_i operands and flag-write enable of the op
//   srcA_o, srcB_o, ALUctrl_o S1 registers driving the ALU
//   ALUresult_i, NZCV_i       ALU outputs
//   out_valid_o / out_ready_i downstream handshake out of S2
//   result_o, illegal_o       S2 registered result and illegal marker
//   flags_o                   architectural NZCV register {N,Z,C,V}
//   cond_i, cond_true_o       condition code in, evaluated condition out
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int DW     = 32,
   parameter int FLAG_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        alu_op_i,
   input  logic [5:0]        funct_i,
   input  logic [DW-1:0]     srcA_i,
   input  logic [DW-1:0]     srcB_i,
   input  logic              flag_we_i,
   output logic [DW-1:0]     srcA_o,
   output logic [DW-1:0]     srcB_o,
   output logic [3:0]        ALUctrl_o,
   input  logic [DW-1:0]     ALUresult_i,
   input  logic [FLAG_W-1:0] NZCV_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DW-1:0]     result_o,
   output logic              illegal_o,
   output logic [FLAG_W-1:0] flags_o,
   input  logic [3:0]        cond_i,
   output logic              cond_true_o
);

   // Bit positions inside the {N,Z,C,V} flag vector.
   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_OR   = 4'b0001;
   localparam logic [3:0] CTRL_ADD  = 4'b0010;
   localparam logic [3:0] CTRL_SUB  = 4'b0110;
   localparam logic [3:0] CTRL_SLT  = 4'b0111;
   localparam logic [3:0] CTRL_NOR  = 4'b1100;
   localparam logic [3:0] CTRL_NAND = 4'b1101;
   localparam logic [3:0] CTRL_ILL  = 4'b1111;

   // S1 state
   logic              s1_v_reg;
   logic [DW-1:0]     s1_a_reg;
   logic [DW-1:0]     s1_b_reg;
   logic [3:0]        s1_ctrl_reg;
   logic              s1_ill_reg;
   logic              s1_fwe_reg;

   // S2 state
   logic              s2_v_reg;
   logic [DW-1:0]     result_reg;
   logic              s2_ill_reg;
   logic [FLAG_W-1:0] flags_reg;

   // Decode results for the op currently offered upstream
   logic [3:0]        ctrl_next;
   logic              ill_next;

   logic              adv2;
   logic              s1_load;
   logic              s1_adv;

   // -------------------------------------------------------------------------
   // Handshake. S2 can take a new op when empty or draining this cycle; S1
   // can accept when empty or when its op moves on, so a full pipeline
   // streams one op per cycle without a bubble.
   // -------------------------------------------------------------------------
   assign adv2       = ~s2_v_reg | out_ready_i;
   assign in_ready_o = ~s1_v_reg | adv2;
   assign s1_load    = in_valid_i & in_ready_o;
   assign s1_adv     = s1_v_reg & adv2;

   // -------------------------------------------------------------------------
   // ALUOp / funct decode. Anything not listed maps to the all-ones code,
   // for which the ALU outputs zero, and is marked illegal.
   // -------------------------------------------------------------------------
   always_comb begin
      ctrl_next = CTRL_ILL;
      ill_next  = 1'b1;
      case (alu_op_i)
         3'b000: begin ctrl_next = CTRL_ADD;  ill_next = 1'b0; end
         3'b001: begin ctrl_next = CTRL_SUB;  ill_next = 1'b0; end
         3'b011: begin ctrl_next = CTRL_AND;  ill_next = 1'b0; end
         3'b100: begin ctrl_next = CTRL_OR;   ill_next = 1'b0; end
         3'b101: begin ctrl_next = CTRL_SLT;  ill_next = 1'b0; end
         3'b110: begin ctrl_next = CTRL_NAND; ill_next = 1'b0; end
         3'b010: begin
            case (funct_i)
               6'b100000: begin ctrl_next = CTRL_ADD; ill_next = 1'b0; end
               6'b100010: begin ctrl_next = CTRL_SUB; ill_next = 1'b0; end
               6'b100100: begin ctrl_next = CTRL_AND; ill_next = 1'b0; end
               6'b100101: begin ctrl_next = CTRL_OR;  ill_next = 1'b0; end
               6'b101010: begin ctrl_next = CTRL_SLT; ill_next = 1'b0; end
               6'b100111: begin ctrl_next = CTRL_NOR; ill_next = 1'b0; end
               default: begin
                  ctrl_next = CTRL_ILL;
                  ill_next  = 1'b1;
               end
            endcase
         end
         default: begin
            ctrl_next = CTRL_ILL;
            ill_next  = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // S1: operand/control registers. Held unchanged while stalled.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_v_reg    <= 1'b0;
         s1_a_reg    <= '0;
         s1_b_reg    <= '0;
         s1_ctrl_reg <= '0;
         s1_ill_reg  <= 1'b0;
         s1_fwe_reg  <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_v_reg    <= 1'b1;
            s1_a_reg    <= srcA_i;
            s1_b_reg    <= srcB_i;
            s1_ctrl_reg <= ctrl_next;
            s1_ill_reg  <= ill_next;
            s1_fwe_reg  <= flag_we_i;
         end else if (s1_adv) begin
            s1_v_reg <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // S2: result capture and architectural flags. Flags change only at the
   // moment a legal flag-setting op enters S2, never while S2 is stalled.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_v_reg   <= 1'b0;
         result_reg <= '0;
         s2_ill_reg <= 1'b0;
         flags_reg  <= '0;
      end else begin
         if (s1_adv) begin
            s2_v_reg   <= 1'b1;
            result_reg <= ALUresult_i;
            s2_ill_reg <= s1_ill_reg;
            if (s1_fwe_reg && !s1_ill_reg) begin
               flags_reg <= NZCV_i;
            end
         end else if (out_ready_i) begin
            s2_v_reg <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Condition evaluation
   // -------------------------------------------------------------------------
   logic [FLAG_W-1:0] eval_flags;

`ifdef ALU_FLAG_BYPASS_EN
   // Forward the live ALU flags exactly when they are about to be committed.
   assign eval_flags = (s1_adv && s1_fwe_reg && !s1_ill_reg) ? NZCV_i : flags_reg;
`else
   assign eval_flags = flags_reg;
`endif

   // Codes 0..11 come in complementary pairs: even code is the base
   // condition, odd code its inverse (LE is exactly ~GT, GE is ~LT).
   logic [5:0]  pair_base;
   logic [15:0] cond_vec;
   logic        n_xor_v;

   assign n_xor_v      = eval_flags[FN] ^ eval_flags[FV];
   assign pair_base[0] = eval_flags[FZ];
   assign pair_base[1] = eval_flags[FC];
   assign pair_base[2] = eval_flags[FN];
   assign pair_base[3] = eval_flags[FV];
   assign pair_base[4] = n_xor_v;
   assign pair_base[5] = ~eval_flags[FZ] & ~n_xor_v;

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_cond_pair
         assign cond_vec[2*gi]   = pair_base[gi];
         assign cond_vec[2*gi+1] = ~pair_base[gi];
      end
   endgenerate

   // 1100, 1101, 1111 never true; 1110 (AL) always true.
   assign cond_vec[15:12] = 4'b0100;

   assign cond_true_o = cond_vec[cond_i];

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign srcA_o      = s1_a_reg;
   assign srcB_o      = s1_b_reg;
   assign ALUctrl_o   = s1_ctrl_reg;
   assign out_valid_o = s2_v_reg;
   assign result_o    = result_reg;
   assign illegal_o   = s2_ill_reg;
   assign flags_o     = flags_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Bench for alu_issue_ctrl. A behavioural ALU closes the loop from the S1
// outputs back into ALUresult_i/NZCV_i. A decode vector table, directed
// multi-cycle sequences and a randomized stream checked against an
// operation-level reference model (queue of expected retirements) exercise
// the block.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [2:0]  alu_op_i;
   logic [5:0]  funct_i;
   logic [31:0] srcA_i;
   logic [31:0] srcB_i;
   logic        flag_we_i;
   logic [31:0] srcA_o;
   logic [31:0] srcB_o;
   logic [3:0]  ALUctrl_o;
   logic [31:0] ALUresult_i;
   logic [3:0]  NZCV_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic        illegal_o;
   logic [3:0]  flags_o;
   logic [3:0]  cond_i;
   logic        cond_true_o;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DW(32), .FLAG_W(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .alu_op_i    (alu_op_i),
      .funct_i     (funct_i),
      .srcA_i      (srcA_i),
      .srcB_i      (srcB_i),
      .flag_we_i   (flag_we_i),
      .srcA_o      (srcA_o),
      .srcB_o      (srcB_o),
      .ALUctrl_o   (ALUctrl_o),
      .ALUresult_i (ALUresult_i),
      .NZCV_i      (NZCV_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .illegal_o   (illegal_o),
      .flags_o     (flags_o),
      .cond_i      (cond_i),
      .cond_true_o (cond_true_o)
   );

   typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_NAND, K_NOR, K_ILL} kind_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Operation meaning of each instruction encoding (what the op does).
   function automatic kind_t ref_kind(input logic [2:0] op, input logic [5:0] fn);
      case (op)
         3'd0: return K_ADD;
         3'd1: return K_SUB;
         3'd3: return K_AND;
         3'd4: return K_OR;
         3'd5: return K_SLT;
         3'd6: return K_NAND;
         3'd2: begin
            case (fn)
               6'd32: return K_ADD;
               6'd34: return K_SUB;
               6'd36: return K_AND;
               6'd37: return K_OR;
               6'd42: return K_SLT;
               6'd39: return K_NOR;
               default: return K_ILL;
            endcase
         end
         default: return K_ILL;
      endcase
   endfunction

   // Behavioural ALU: returns {result, N, Z, C, V}.
   function automatic logic [35:0] exec(input kind_t k, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] wide;
      logic [31:0] r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (k)
         K_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[31:0];
            c = wide[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         K_SUB: begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         K_AND:  r = a & b;
         K_OR:   r = a | b;
         K_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         K_NAND: r = ~(a & b);
         K_NOR:  r = ~(a | b);
         default: return 36'd0;
      endcase
      return {r, r[31], (r == 32'd0), c, v};
   endfunction

   function automatic kind_t ctrl_kind(input logic [3:0] c);
      case (c)
         4'b0010: return K_ADD;
         4'b0110: return K_SUB;
         4'b0000: return K_AND;
         4'b0001: return K_OR;
         4'b0111: return K_SLT;
         4'b1101: return K_NAND;
         4'b1100: return K_NOR;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return n != v;
         4'd9:  return n == v;
         4'd10: return !z && (n == v);
         4'd11: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // External ALU driven by the S1 registers
   always_comb begin
      {ALUresult_i, NZCV_i} = exec(ctrl_kind(ALUctrl_o), srcA_o, srcB_o);
   end

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      logic [31:0] res;
      logic        ill;
      logic [3:0]  flags;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] model_flags = 4'd0;
   bit         scb_en = 1'b0;
   bit         acc_seen = 1'b0;

   always @(negedge clk) begin
      if (scb_en && !rst_i) begin
         exp_t e;
         logic [35:0] x;
         kind_t k;
`ifndef ALU_FLAG_BYPASS_EN
         if (out_valid_o && exp_q.size() > 0)
            chk("rnd_cond", {31'd0, cond_true_o}, {31'd0, cond_eval(cond_i, exp_q[0].flags)});
`endif
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("rnd_unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("xfer result=%h illegal=%0b flags=%b", result_o, illegal_o, flags_o);
               chk("rnd_result",  result_o, e.res);
               chk("rnd_illegal", {31'd0, illegal_o}, {31'd0, e.ill});
               chk("rnd_flags",   {28'd0, flags_o}, {28'd0, e.flags});
            end
         end
         acc_seen = in_valid_i && in_ready_o;
         if (acc_seen) begin
            k = ref_kind(alu_op_i, funct_i);
            if (k == K_ILL) begin
               e.res = 32'd0;
               e.ill = 1'b1;
            end else begin
               x = exec(k, srcA_i, srcB_i);
               e.res = x[35:4];
               e.ill = 1'b0;
               if (flag_we_i) model_flags = x[3:0];
            end
            e.flags = model_flags;
            exp_q.push_back(e);
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic send(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic fwe);
      bit ok;
      @(posedge clk); #1;
      in_valid_i = 1'b1;
      alu_op_i   = op;
      funct_i    = fn;
      srcA_i     = a;
      srcB_i     = b;
      flag_we_i  = fwe;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (in_ready_o) ok = 1'b1;
      end
      chk("send_timeout", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      $display("sent op=%b funct=%b a=%h b=%h fwe=%0b", op, fn, a, b, fwe);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [5:0] fn;
      logic [3:0] ctrl;
      logic       ill;
   } dec_vec_t;

   dec_vec_t    vecs[14];
   logic [31:0] got[8];
   int          ngot;

   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; alu_op_i = 3'd0; funct_i = 6'd0;
      srcA_i = 32'd0; srcB_i = 32'd0; flag_we_i = 1'b0; out_ready_i = 1'b1; cond_i = 4'd0;

      vecs[0]  = '{3'b000, 6'b000000, 4'b0010, 1'b0};
      vecs[1]  = '{3'b001, 6'b111111, 4'b0110, 1'b0};
      vecs[2]  = '{3'b011, 6'b000000, 4'b0000, 1'b0};
      vecs[3]  = '{3'b100, 6'b000000, 4'b0001, 1'b0};
      vecs[4]  = '{3'b101, 6'b000000, 4'b0111, 1'b0};
      vecs[5]  = '{3'b110, 6'b000000, 4'b1101, 1'b0};
      vecs[6]  = '{3'b010, 6'b100000, 4'b0010, 1'b0};
      vecs[7]  = '{3'b010, 6'b100010, 4'b0110, 1'b0};
      vecs[8]  = '{3'b010, 6'b100100, 4'b0000, 1'b0};
      vecs[9]  = '{3'b010, 6'b100101, 4'b0001, 1'b0};
      vecs[10] = '{3'b010, 6'b101010, 4'b0111, 1'b0};
      vecs[11] = '{3'b010, 6'b100111, 4'b1100, 1'b0};
      vecs[12] = '{3'b111, 6'b100000, 4'b1111, 1'b1};
      vecs[13] = '{3'b010, 6'b100001, 4'b1111, 1'b1};

      // 1: reset held two cycles while an op is offered
      in_valid_i = 1'b1; alu_op_i = 3'b000; srcA_i = 32'd1; srcB_i = 32'd1; flag_we_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_flags", {28'd0, flags_o}, 32'd0);
      chk("rst_aluctrl", {28'd0, ALUctrl_o}, 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b0; in_valid_i = 1'b0;
      @(negedge clk);
      chk("rst_no_capture_srcA", srcA_o, 32'd0);
      @(negedge clk);
      chk("rst_no_capture_valid", {31'd0, out_valid_o}, 32'd0);

      // decode table
      for (int i = 0; i < 14; i++) begin
         send(vecs[i].op, vecs[i].fn, 32'd6, 32'd3, 1'b0);
         @(negedge clk);
         chk($sformatf("dec%0d_ctrl", i), {28'd0, ALUctrl_o}, {28'd0, vecs[i].ctrl});
         @(negedge clk);
         chk($sformatf("dec%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
         chk($sformatf("dec%0d_illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].ill});
      end

      // 2: R-type SUB 5-7 sets N, LT true
      cond_i = 4'b1000;
      send(3'b010, 6'b100010, 32'd5, 32'd7, 1'b1);
      @(negedge clk);
      chk("sub_ctrl", {28'd0, ALUctrl_o}, 32'h6);
      chk("sub_srcB", srcB_o, 32'd7);
      @(negedge clk);
      chk("sub_valid", {31'd0, out_valid_o}, 32'd1);
      chk("sub_result", result_o, 32'hFFFF_FFFE);
      chk("sub_flagN", {31'd0, flags_o[3]}, 32'd1);
      chk("sub_flagZ", {31'd0, flags_o[2]}, 32'd0);
      chk("sub_lt", {31'd0, cond_true_o}, 32'd1);

      // 3: back-to-back ADD overflow then AND zero
      @(posedge clk); #1;
      in_valid_i = 1'b1; alu_op_i = 3'b000; srcA_i = 32'h7FFF_FFFF; srcB_i = 32'd1; flag_we_i = 1'b1;
      @(posedge clk); #1;
      alu_op_i = 3'b011; srcA_i = 32'h0F; srcB_i = 32'hF0;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("b2b_valid0", {31'd0, out_valid_o}, 32'd1);
      chk("b2b_result0", result_o, 32'h8000_0000);
      chk("b2b_flagsNV", {30'd0, flags_o[3], flags_o[0]}, 32'd3);
      @(negedge clk);
      chk("b2b_valid1", {31'd0, out_valid_o}, 32'd1);
      chk("b2b_result1", result_o, 32'd0);
      chk("b2b_flags1", {28'd0, flags_o}, 32'b0100);

      // 4: downstream stall with three ops offered
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; alu_op_i = 3'b000; srcA_i = 32'd1; srcB_i = 32'd1; flag_we_i = 1'b0;
      @(posedge clk); #1;
      srcA_i = 32'd2; srcB_i = 32'd2;
      @(posedge clk); #1;
      srcA_i = 32'd3; srcB_i = 32'd3;
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("stall_result", result_o, 32'd2);
      @(posedge clk);
      @(negedge clk);
      chk("stall_in_ready2", {31'd0, in_ready_o}, 32'd0);
      chk("stall_hold_result", result_o, 32'd2);
      chk("stall_hold_s1", srcA_o, 32'd2);
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      ngot = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid_o && out_ready_i && ngot < 8) begin
            got[ngot] = result_o;
            ngot++;
         end
         if (in_valid_i && in_ready_o) begin
            @(posedge clk); #1;
            in_valid_i = 1'b0;
         end
      end
      chk("stall_count", ngot, 32'd3);
      chk("stall_order0", got[0], 32'd2);
      chk("stall_order1", got[1], 32'd4);
      chk("stall_order2", got[2], 32'd6);

      // 5: illegal R-type funct leaves flags untouched
      send(3'b010, 6'b000000, 32'd9, 32'd4, 1'b1);
      @(negedge clk);
      chk("ill_ctrl", {28'd0, ALUctrl_o}, 32'hF);
      @(negedge clk);
      chk("ill_flag", {31'd0, illegal_o}, 32'd1);
      chk("ill_result", result_o, 32'd0);
      chk("ill_flags_kept", {28'd0, flags_o}, 32'b0100);

      // 6: flag-setting SUB 3-3 with EQ evaluated in the advance cycle
      send(3'b000, 6'd0, 32'd1, 32'd1, 1'b1);
      cond_i = 4'b0000;
      send(3'b001, 6'd0, 32'd3, 32'd3, 1'b1);
      @(negedge clk);
`ifdef ALU_FLAG_BYPASS_EN
      chk("eq_adv_cycle", {31'd0, cond_true_o}, 32'd1);
`else
      chk("eq_adv_cycle", {31'd0, cond_true_o}, 32'd0);
`endif
      @(negedge clk);
      chk("eq_next_cycle", {31'd0, cond_true_o}, 32'd1);
      chk("eq_flagZ", {31'd0, flags_o[2]}, 32'd1);

      // reset with an op in flight drops it
      @(posedge clk); #1;
      in_valid_i = 1'b1; alu_op_i = 3'b000; srcA_i = 32'd8; srcB_i = 32'd8; flag_we_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0; rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
      end
      chk("midrst_flags", {28'd0, flags_o}, 32'd0);

      // randomized stream against the reference model
      model_flags = 4'd0;
      scb_en = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clk); #1;
         if (!in_valid_i || acc_seen) begin
            if ($urandom_range(0, 3) != 0) begin
               logic [5:0] fl[6];
               fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39};
               in_valid_i = 1'b1;
               alu_op_i   = 3'($urandom_range(0, 7));
               funct_i    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 5)];
               srcA_i     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
               srcB_i     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
               flag_we_i  = 1'($urandom);
            end else begin
               in_valid_i = 1'b0;
            end
         end
         out_ready_i = ($urandom_range(0, 3) != 0);
         cond_i      = 4'($urandom);
      end
      @(posedge clk); #1;
      if (!acc_seen) in_valid_i = 1'b0;
      @(posedge clk); #1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rnd_drained", exp_q.size(), 32'd0);
      scb_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
